// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:4 stream demultiplexer.
package demux_pkg;

    typedef logic [1:0] chan_idx_t;

    typedef enum logic {
        MODE_DIRECTED = 1'b0,
        MODE_RR       = 1'b1
    } mode_e;

    localparam int unsigned NUM_CH = 4;

endpackage

// File: rtl/demux_out_reg.sv
// One-entry output holding register with valid/ready handshake.
module demux_out_reg #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [n-1:0] d,
    input  logic         q_ready,
    output logic [n-1:0] q,
    output logic         q_valid
);

    // A load on the same edge as a drain wins, keeping q_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q       <= d;
            q_valid <= 1'b1;
        end else if (q_ready) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to4.sv
// Registered 1:4 stream demultiplexer: directed or strict round-robin routing
// into four independently handshaked holding registers.
module demux_1to4
    import demux_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic [1:0]   sel,
    input  logic [n-1:0] d,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] q0,
    output logic [n-1:0] q1,
    output logic [n-1:0] q2,
    output logic [n-1:0] q3,
    output logic [3:0]   q_valid,
    input  logic [3:0]   q_ready,
    output logic         busy
);

    chan_idx_t          rr_ptr;
    chan_idx_t          tgt;
    logic               accept;
    logic [NUM_CH-1:0]  load;
    logic [n-1:0]       q_arr [NUM_CH];

    assign tgt      = (mode_e'(mode) == MODE_RR) ? rr_ptr : sel;
    // Strict order: a full target blocks input even if other channels are free.
    assign in_ready = en && !rst && (!q_valid[tgt] || q_ready[tgt]);
    assign accept   = in_valid && in_ready;
    assign busy     = |q_valid;

    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            load[i] = accept && (tgt == chan_idx_t'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept && (mode_e'(mode) == MODE_RR)) begin
            rr_ptr <= rr_ptr + 2'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        demux_out_reg #(.n(n)) u_reg (
            .clk     (clk),
            .rst     (rst),
            .load    (load[g]),
            .d       (d),
            .q_ready (q_ready[g]),
            .q       (q_arr[g]),
            .q_valid (q_valid[g])
        );
    end

    assign q0 = q_arr[0];
    assign q1 = q_arr[1];
    assign q2 = q_arr[2];
    assign q3 = q_arr[3];

endmodule

// File: tb/tb_demux_1to4.sv
// Directed-vector bench for demux_1to4 with hand-computed expectations.
module tb_demux_1to4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] d;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] q0, q1, q2, q3;
    logic [3:0] q_valid;
    logic [3:0] q_ready;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    demux_1to4 #(.n(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sel      (sel),
        .d        (d),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .q0       (q0),
        .q1       (q1),
        .q2       (q2),
        .q3       (q3),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] qsel(int i);
        case (i)
            0:       return q0;
            1:       return q1;
            2:       return q2;
            default: return q3;
        endcase
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0; d = 8'h00;
        in_valid = 1'b0; q_ready = 4'h0;
        cyc(); cyc();
        chk("rst_qvalid", 8'(q_valid), 8'h00);
        chk("rst_q0", q0, 8'h00);
        chk("rst_inready", 8'(in_ready), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        rst = 1'b0;

        // Directed routing, one beat per cycle to each channel.
        en = 1'b1; mode = 1'b0; q_ready = 4'hF; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i); d = 8'hA0 + 8'(i);
            #1 chk("dir_inready", 8'(in_ready), 8'h01);
            cyc();
            chk("dir_q", qsel(i), 8'hA0 + 8'(i));
            chk("dir_qvalid", 8'(q_valid), 8'(4'b0001 << i));
        end
        in_valid = 1'b0;
        cyc();
        chk("dir_drained", 8'(q_valid), 8'h00);
        chk("dir_stale_q3", q3, 8'hA3);

        // Backpressure isolation on channel 2.
        q_ready = 4'b1011; in_valid = 1'b1; sel = 2'd2; d = 8'h11;
        #1 chk("bp_first_rdy", 8'(in_ready), 8'h01);
        cyc();
        chk("bp_q2", q2, 8'h11);
        chk("bp_qv1", 8'(q_valid), 8'h04);
        d = 8'h22;
        #1 chk("bp_second_rdy", 8'(in_ready), 8'h00);
        cyc();
        chk("bp_q2_hold", q2, 8'h11);
        chk("bp_qv2", 8'(q_valid), 8'h04);
        sel = 2'd1; d = 8'h33;
        #1 chk("bp_third_rdy", 8'(in_ready), 8'h01);
        cyc();
        chk("bp_q1", q1, 8'h33);
        chk("bp_qv3", 8'(q_valid), 8'h06);
        chk("bp_q2_hold2", q2, 8'h11);
        sel = 2'd2; d = 8'h22; q_ready = 4'hF;
        #1 chk("bp_refill_rdy", 8'(in_ready), 8'h01);
        cyc();
        chk("bp_q2_refill", q2, 8'h22);
        chk("bp_qv4", 8'(q_valid), 8'h04);
        in_valid = 1'b0;
        cyc();
        chk("bp_drained", 8'(q_valid), 8'h00);

        // Round-robin order 0,1,2,3,0,1; sel is ignored.
        mode = 1'b1; in_valid = 1'b1; sel = 2'd3;
        for (int k = 1; k <= 6; k++) begin
            d = 8'(k);
            #1 chk("rr_inready", 8'(in_ready), 8'h01);
            cyc();
            chk("rr_q", qsel((k - 1) % 4), 8'(k));
            chk("rr_qvalid", 8'(q_valid), 8'(4'b0001 << ((k - 1) % 4)));
        end
        chk("rr_ptr6", 8'(dut.rr_ptr), 8'h02);
        // Fill channel 2 directed so the pointed-to channel is full.
        mode = 1'b0; sel = 2'd2; d = 8'h70; q_ready = 4'b1011;
        cyc();
        chk("rr_ptr_dir_hold", 8'(dut.rr_ptr), 8'h02);
        chk("rr_q2_full", q2, 8'h70);
        mode = 1'b1; d = 8'h07;
        #1 chk("rr_stall_rdy", 8'(in_ready), 8'h00);
        cyc(); cyc();
        chk("rr_stall_ptr", 8'(dut.rr_ptr), 8'h02);
        chk("rr_stall_q2", q2, 8'h70);
        chk("rr_noskip", 8'(q_valid), 8'h04);
        q_ready = 4'hF;
        #1 chk("rr_unstall_rdy", 8'(in_ready), 8'h01);
        cyc();
        chk("rr_q2_beat7", q2, 8'h07);
        chk("rr_ptr7", 8'(dut.rr_ptr), 8'h03);
        chk("rr_qv7", 8'(q_valid), 8'h04);

        // Enable low: no accept, held beats still drain.
        q_ready = 4'h0; mode = 1'b0; sel = 2'd0; d = 8'h55;
        cyc();
        chk("en_q0_load", q0, 8'h55);
        mode = 1'b1; en = 1'b0; d = 8'h99; q_ready = 4'b0001;
        #1 chk("en_low_rdy", 8'(in_ready), 8'h00);
        cyc();
        chk("en_low_drain", 8'(q_valid), 8'h04);
        cyc();
        chk("en_low_ptr", 8'(dut.rr_ptr), 8'h03);
        chk("en_low_q3", 8'(q_valid[3]), 8'h00);
        en = 1'b1;
        #1 chk("en_high_rdy", 8'(in_ready), 8'h01);
        cyc();
        chk("en_q3", q3, 8'h99);
        chk("en_ptr_wrap", 8'(dut.rr_ptr), 8'h00);
        chk("en_qv", 8'(q_valid), 8'h0C);
        in_valid = 1'b0;

        // Async reset mid-stream with channels 1 and 2 holding.
        q_ready = 4'b1001;
        cyc();
        q_ready = 4'h0; in_valid = 1'b1; d = 8'h41;
        cyc();
        d = 8'h42;
        cyc();
        chk("mid_ptr", 8'(dut.rr_ptr), 8'h02);
        q_ready = 4'b0001; in_valid = 1'b0;
        cyc();
        q_ready = 4'h0; in_valid = 1'b1;
        chk("mid_qvalid", 8'(q_valid), 8'h06);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_qvalid", 8'(q_valid), 8'h00);
        chk("mid_rst_q1", q1, 8'h00);
        chk("mid_rst_q2", q2, 8'h00);
        chk("mid_rst_rdy", 8'(in_ready), 8'h00);
        in_valid = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_ptr", 8'(dut.rr_ptr), 8'h00);
        chk("post_rst_rdy", 8'(in_ready), 8'h01);

        // Full throughput into channel 3.
        mode = 1'b0; sel = 2'd3; q_ready = 4'b1000; in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            d = 8'(k);
            #1 chk("tp_rdy", 8'(in_ready), 8'h01);
            cyc();
            chk("tp_q3", q3, 8'(k));
            chk("tp_qv3", 8'(q_valid), 8'h08);
        end
        chk("tp_busy", 8'(busy), 8'h01);
        in_valid = 1'b0;
        cyc();
        chk("tp_drained", 8'(q_valid), 8'h00);
        chk("tp_idle_busy", 8'(busy), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_1to4.md
Name: demux_1to4

Overview:
Registered 1:4 stream demultiplexer, the distribution-side counterpart of mux_4to1 in the element catalog. It accepts one n-bit beat per cycle on a valid/ready input and routes it to one of four output channels. The channel is either named by sel (directed mode) or chosen by an internal rotating pointer (round-robin mode). Each output channel has a one-entry holding register with its own valid/ready handshake, so a stalled channel does not block beats bound for other channels.

Parameters:
n, 8, data width of input and each output channel

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  block enable; when low no new beats are accepted
mode  input  1  0 = directed (use sel), 1 = round-robin
sel  input  2  target channel in directed mode; ignored in round-robin
d  input  n  input data beat
in_valid  input  1  d/sel are valid this cycle
in_ready  output  1  block can accept the beat this cycle
q0, q1, q2, q3  output  n  channel data registers
q_valid  output  4  bit i = channel i holds a beat
q_ready  input  4  bit i = downstream consumer takes channel i this cycle
busy  output  1  OR of q_valid

Behaviour:
- Reset (rst high, async):
  - q0..q3 = 0, q_valid = 0, round-robin pointer rr_ptr = 0.
  - in_ready is forced 0 while rst is high.
- Target channel: tgt = sel when mode = 0, tgt = rr_ptr when mode = 1.
- in_ready (combinational) = en && !rst && (!q_valid[tgt] || q_ready[tgt]).
- Accept: in_valid && in_ready at a rising edge.
  - q[tgt] <= d and q_valid[tgt] <= 1.
  - Latency is 1 cycle: the beat is visible on q[tgt]/q_valid[tgt] in the cycle after acceptance.
- Drain: q_valid[i] && q_ready[i] at an edge clears q_valid[i] unless channel i is refilled at the same edge.
  - Data registers are not cleared on drain; the stale value remains.
- Simultaneous drain and fill on the same channel: q_valid stays 1 and the new data is loaded. This gives full throughput of 1 beat/cycle into one channel.
- Fill of channel A and drain of channel B at the same edge are independent.
- Hold: while q_valid[i] && !q_ready[i], q[i] is stable.
- Round-robin pointer:
  - Advances 0→1→2→3→0 only on an accepted beat in mode 1.
  - Holds on stalls, when en is low, and in mode 0.
  - If the pointed-to channel is full and not draining, in_ready = 0. The block never skips ahead to another free channel (strict order).
- Mode/sel are sampled only with an accepted beat. A mode change takes effect on the next accepted beat, and rr_ptr keeps its value across mode changes.
- en low:
  - in_ready = 0.
  - Already-held beats still drain normally.
  - Outputs are never tri-stated; this differs from mux_4to1's high-Z on disable.
- No in_valid: nothing changes except drains. in_ready may be high while in_valid is low.
- Reset mid-operation: all held beats are discarded immediately (q_valid → 0), with no partial transfer.

Decomposition:
- Package demux_pkg:
  - typedef logic [1:0] chan_idx_t
  - constants MODE_DIRECTED = 1'b0, MODE_RR = 1'b1
  - constant NUM_CH = 4
- Sub-module demux_out_reg (#n):
  - One channel holding register with load, q_ready, q, q_valid and async reset.
  - Instantiated 4 times.
- Top level contains the target selection, in_ready logic and rr_ptr.

Test Plan:
1. Reset check: assert rst mid-stream with q_valid = 4'b0110 → q_valid = 0, q0..q3 = 0, in_ready = 0 with no clock edge required; after release, rr_ptr = 0.
2. Directed routing: mode = 0, q_ready = 4'hF, send d = 8'hA0..A3 with sel = 0..3 on consecutive cycles → each q[i] = 8'hA0+i with q_valid[i] = 1 exactly one cycle after its accept; in_ready stays 1 throughout.
3. Backpressure isolation: mode = 0, q_ready[2] = 0, send 8'h11 and 8'h22 both to sel = 2, then 8'h33 to sel = 1.
   - First beat: q2 = 8'h11 and held stable.
   - Second beat: in_ready = 0 while sel = 2 is presented.
   - Re-present the third beat (sel = 1): accepted, q1 = 8'h33.
   - Raise q_ready[2]: second beat accepted with drain+fill on the same edge, q2 = 8'h22, q_valid[2] stays 1.
4. Round-robin: mode = 1, q_ready = 4'hF, send 6 beats 1..6 → channel order 0,1,2,3,0,1 and rr_ptr = 2. Then stall channel 2 and send beat 7 → in_ready = 0 and rr_ptr is unchanged until channel 2 drains.
5. Enable: en = 0 with in_valid = 1 and channel 0 holding 8'h55 with q_ready[0] = 1 → no accept, rr_ptr holds, channel 0 drains (q_valid[0] → 0). After en = 1, the pending beat is accepted next edge.
6. Full throughput: mode = 0, sel = 3, q_ready[3] = 1, 16 back-to-back beats 0..15 → q3 shows 0..15 on consecutive cycles, q_valid[3] continuously 1, no bubbles.
